rv_test_status_monitor: RTL and testbench

- Synthesizable riscv-tests result monitor, directly downstream of the core's instruction decode stage and register file on the ZedBoard top.
- Watches decoded instructions; on ECALL, latches gp (x3) and classifies the run as PASS, FAIL or TIMEOUT.
- Results are sticky; they drive gpio_pin_out LEDs on hardware and status flags read by the simulation bench.

---
 rtl/rv_test_status_monitor.sv | 168 ++++++++++++++++
 tb/tb_rv_test_status_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rv_test_status_monitor.sv
// rv_test_status_monitor: riscv-tests result monitor. Watches decoded
// instructions, latches gp (x3) on ECALL and reports PASS/FAIL/TIMEOUT.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   inst_valid      inst is a real decoded instruction this cycle
//   inst, pc        instruction word at decode and its PC
//   gp_value        current x3 from the register file
//   clear           synchronous return to IDLE, counters/results zeroed
//   done/pass/fail/timeout  sticky result flags (one-hot when done)
//   fail_testnum    gp_value[XLEN-1:1] latched at a failing ECALL
//   retired         saturating count of valid instructions
//   led_out         {done, pass, fail, timeout, state nibble}
//   ecall_pc        PC of the terminating ECALL (zero unless enabled)
//
// Optional: define RV_TEST_MON_ECALL_PC_EN to build the ecall_pc capture.

module rv_test_status_monitor #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int CNT_W          = 24,
    parameter int HB_BIT         = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] gp_value,
    input  logic            clear,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [XLEN-2:0] fail_testnum,
    output logic [31:0]     retired,
    output logic [7:0]      led_out,
    output logic [XLEN-1:0] ecall_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [31:0]      ECALL_WORD = 32'h0000_0073;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ret_q, ret_d, ret_inc;
    logic [XLEN-2:0]   num_q, num_d;
    logic              is_ecall;
    logic              gp_one;
    logic              ecall_end;
    logic [3:0]        led_lo;

    assign is_ecall = inst_valid && (inst == ECALL_WORD);
    assign gp_one   = (gp_value == XLEN'(1));
    assign ret_inc  = (ret_q == 32'hFFFF_FFFF) ? ret_q : ret_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ret_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ret_d     = ret_q;
        num_d     = num_q;
        ecall_end = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ret_d   = '0;
            num_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (inst_valid) begin
                        ret_d   = ret_inc;
                        state_d = S_RUN;
                        // an ECALL as the very first instruction ends the run
                        if (is_ecall) begin
                            ecall_end = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (inst_valid) begin
                        ret_d = ret_inc;
                    end
                    // ECALL beats a coincident timeout
                    if (is_ecall) begin
                        ecall_end = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_TIMEOUT;
                    end
                end
                S_PASS, S_FAIL, S_TIMEOUT: begin
                end
            endcase
            if (ecall_end) begin
                if (gp_one) begin
                    state_d = S_PASS;
                end else begin
                    state_d = S_FAIL;
                    num_d   = gp_value[XLEN-1:1];
                end
            end
        end
    end

    assign pass         = (state_q == S_PASS);
    assign fail         = (state_q == S_FAIL);
    assign timeout      = (state_q == S_TIMEOUT);
    assign done         = pass || fail || timeout;
    assign fail_testnum = num_q;
    assign retired      = ret_q;

    always_comb begin
        led_lo = 4'h0;
        unique case (state_q)
            S_IDLE:    led_lo = 4'h0;
            S_RUN:     led_lo = {3'b000, cnt_q[HB_BIT]};
            S_PASS:    led_lo = 4'hF;
            S_FAIL:    led_lo = num_q[3:0];
            S_TIMEOUT: led_lo = 4'hA;
        endcase
    end

    assign led_out = {done, pass, fail, timeout, led_lo};

`ifdef RV_TEST_MON_ECALL_PC_EN
    logic [XLEN-1:0] epc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= '0;
        end else if (clear) begin
            epc_q <= '0;
        end else if (ecall_end) begin
            epc_q <= pc;
        end
    end

    assign ecall_pc = epc_q;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign ecall_pc  = '0;
`endif

endmodule

// File: tb/tb_rv_test_status_monitor.sv
// Scoreboard bench for rv_test_status_monitor: directed stimulus pushes
// expected snapshots, a negedge monitor pops and compares them.

module tb_rv_test_status_monitor;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef RV_TEST_MON_ECALL_PC_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  flg;
        logic [30:0] fn;
        logic [31:0] ret;
        logic [7:0]  led;
        logic [31:0] epc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [31:0] gp_value = '0;
    logic        clear = 1'b0;
    logic        done, pass, fail, timeout;
    logic [30:0] fail_testnum;
    logic [31:0] retired;
    logic [7:0]  led_out;
    logic [31:0] ecall_pc;

    exp_t q[$];
    exp_t m;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv_test_status_monitor #(
        .XLEN(32),
        .TIMEOUT_CYCLES(16),
        .CNT_W(8),
        .HB_BIT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inst_valid(inst_valid),
        .inst(inst),
        .pc(pc),
        .gp_value(gp_value),
        .clear(clear),
        .done(done),
        .pass(pass),
        .fail(fail),
        .timeout(timeout),
        .fail_testnum(fail_testnum),
        .retired(retired),
        .led_out(led_out),
        .ecall_pc(ecall_pc)
    );

    function automatic exp_t mk(string n, logic [3:0] flg, logic [30:0] fn,
                                logic [31:0] ret, logic [7:0] led,
                                logic [31:0] epc);
        exp_t e;
        e.name = n;
        e.flg  = flg;
        e.fn   = fn;
        e.ret  = ret;
        e.led  = led;
        e.epc  = EPC_EN ? epc : 32'h0;
        return e;
    endfunction

    function automatic exp_t zero(string n);
        return mk(n, 4'b0000, 31'd0, 32'd0, 8'h00, 32'h0);
    endfunction

    function automatic exp_t run(string n, logic [31:0] ret, int c);
        logic [7:0] l;
        l = 8'((c >> 2) & 1);
        return mk(n, 4'b0000, 31'd0, ret, l, 32'h0);
    endfunction

    task automatic cyc(input logic v, input logic [31:0] i,
                       input logic [31:0] p, input logic [31:0] g,
                       input logic c, input exp_t e);
        inst_valid = v;
        inst       = i;
        pc         = p;
        gp_value   = g;
        clear      = c;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            logic [105:0] act, want;
            m    = q.pop_front();
            act  = {done, pass, fail, timeout, fail_testnum,
                    retired, led_out, ecall_pc};
            want = {m.flg, m.fn, m.ret, m.led, m.epc};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL %s: got flags=%b num=%h ret=%0d led=%h epc=%h want flags=%b num=%h ret=%0d led=%h epc=%h",
                         m.name, {done, pass, fail, timeout}, fail_testnum,
                         retired, led_out, ecall_pc, m.flg, m.fn, m.ret,
                         m.led, m.epc);
            end
        end
    end

    initial begin
        #2;
        q.push_back(zero("reset"));
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(0, 32'h0, 32'h0, 32'h0, 0, zero("idle_hold"));
        cyc(0, ECALL, 32'h10, 32'h1, 0, zero("bubble_ecall"));

        // PASS
        cyc(1, ADDI, 32'h194, 32'h0, 0, run("pass_run1", 32'd1, 0));
        cyc(1, ADDI, 32'h198, 32'h0, 0, run("pass_run2", 32'd2, 1));
        cyc(1, ADDI, 32'h19C, 32'h0, 0, run("pass_run3", 32'd3, 2));
        cyc(1, ECALL, 32'h1A0, 32'h1, 0,
            mk("pass", 4'b1100, 31'd0, 32'd4, 8'hCF, 32'h1A0));
        cyc(1, ECALL, 32'h1A4, 32'h7, 0,
            mk("pass_sticky", 4'b1100, 31'd0, 32'd4, 8'hCF, 32'h1A0));
        cyc(0, 32'h0, 32'h0, 32'h0, 1, zero("clear_pass"));

        // FAIL straight from IDLE
        cyc(1, ECALL, 32'h40, 32'h7, 0,
            mk("fail", 4'b1010, 31'd3, 32'd1, 8'hA3, 32'h40));
        cyc(1, ECALL, 32'h44, 32'h1, 0,
            mk("fail_sticky", 4'b1010, 31'd3, 32'd1, 8'hA3, 32'h40));
        cyc(0, 32'h0, 32'h0, 32'h0, 1, zero("clear_fail"));

        // EBREAK is not ECALL, then TIMEOUT
        cyc(1, ADDI, 32'h80, 32'h0, 0, run("to_run", 32'd1, 0));
        cyc(1, EBREAK, 32'h84, 32'h1, 0, run("ebreak", 32'd2, 1));
        for (int n = 2; n <= 15; n++) begin
            cyc(0, ECALL, 32'h88, 32'h1, 0, run("to_count", 32'd2, n));
        end
        cyc(0, 32'h0, 32'h0, 32'h0, 0,
            mk("timeout", 4'b1001, 31'd0, 32'd2, 8'h9A, 32'h0));
        cyc(0, 32'h0, 32'h0, 32'h0, 1, zero("clear_timeout"));

        // ECALL on the timeout cycle
        cyc(1, ADDI, 32'h2C0, 32'h0, 0, run("col_run", 32'd1, 0));
        for (int n = 1; n <= 15; n++) begin
            cyc(0, 32'h0, 32'h0, 32'h0, 0, run("col_count", 32'd1, n));
        end
        cyc(1, ECALL, 32'h300, 32'h1, 0,
            mk("collision", 4'b1100, 31'd0, 32'd2, 8'hCF, 32'h300));
        cyc(0, 32'h0, 32'h0, 32'h0, 1, zero("clear_collision"));

        // clear beats ECALL
        cyc(1, ADDI, 32'h310, 32'h0, 0, run("clr_run", 32'd1, 0));
        cyc(1, ECALL, 32'h314, 32'h1, 1, zero("clear_vs_ecall"));
        cyc(0, 32'h0, 32'h0, 32'h0, 0, zero("clear_idle"));

        // asynchronous reset mid-RUN
        cyc(1, ADDI, 32'h400, 32'h0, 0, run("rst_run", 32'd1, 0));
        for (int n = 1; n <= 9; n++) begin
            cyc(1, ADDI, 32'h400 + 32'(4 * n), 32'h0, 0,
                run("rst_count", 32'(n + 1), n));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.push_back(zero("async_reset"));
        inst_valid = 1'b0;
        @(posedge clk);
        #1 q.push_back(zero("reset_held"));
        #1 rst_n = 1'b1;
        cyc(0, 32'h0, 32'h0, 32'h0, 0, zero("post_reset_idle"));

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
